vblank_scheduler: RTL and testbench

- Shares the vertical-blanking window of the 640x480@60 Hz VGA timing among N game-logic requesters, e.g. bird physics, pipe scroll, score update and RAM writer.
- Watches the line pointer from the VGA timing block and emits a per-frame tick at blanking entry.
- Grants exclusive update access one requester at a time, round-robin, and revokes access when blanking ends, so state never changes mid-scan.

---
 rtl/vblank_scheduler.sv | 107 ++++++++++
 tb/tb_vblank_scheduler.sv | 134 +++++++++++++
 2 files changed

// File: rtl/vblank_scheduler.sv
// vblank_scheduler: round-robin sharing of the VGA vertical-blanking window among N requesters
module vblank_scheduler #(
  parameter int N         = 4,
  parameter int VIS_LINES = 480,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       y_ptr,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     done,
  output logic [N-1:0]     grant,
  output logic             frame_tick,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;
  state_t state, state_n;
  logic vblank_q, vb, entry, rel, rel_norm;
  logic [N-1:0] served, served_n, eligible, grant_n;
  logic [PW-1:0] rr_ptr, rr_n, gi, gi_n, pick;
  logic [HW-1:0] hold_cnt, hold_n;
  logic overrun_n, timeout_n;
  assign vb       = int'(y_ptr) >= VIS_LINES;
  assign entry    = vb & ~vblank_q;
  assign eligible = req & ~served;
  assign rel_norm = done[gi] | ~req[gi];
  assign rel      = rel_norm | ~vb | (hold_cnt == HW'(TIMEOUT - 1));
  assign busy     = |grant;
  // first eligible requester at or after rr_ptr, wrapping modulo N
  always_comb begin
    pick = rr_ptr;
    for (int i = N - 1; i >= 0; i--)
      if (eligible[(int'(rr_ptr) + i) % N]) pick = PW'((int'(rr_ptr) + i) % N);
  end
  // next-state and registered-output computation
  always_comb begin
    state_n   = state;
    grant_n   = grant;
    served_n  = served;
    rr_n      = rr_ptr;
    gi_n      = gi;
    hold_n    = hold_cnt;
    overrun_n = overrun;
    timeout_n = timeout_err;
    case (state)
      ARB: begin
        state_n = (!vb || eligible == '0) ? IDLE : GRANT;
        if (vb && eligible != '0) begin
          grant_n = N'(1) << pick;
          gi_n    = pick;
          hold_n  = '0;
        end
      end
      GRANT: begin
        hold_n = hold_cnt + HW'(1);
        if (rel) begin
          grant_n      = '0;
          served_n[gi] = 1'b1;
          rr_n         = PW'((int'(gi) + 1) % N);
          overrun_n    = overrun | (~rel_norm & ~vb);
          timeout_n    = timeout_err | (~rel_norm & vb);
          state_n      = vb ? ARB : IDLE;
        end
      end
      default: ;
    endcase
    if (entry) begin
      served_n = '0;
      grant_n  = '0;
      state_n  = ARB;
    end
  end
  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      vblank_q    <= 1'b1;
      frame_tick  <= 1'b0;
      frame_cnt   <= '0;
      served      <= '0;
      rr_ptr      <= '0;
      gi          <= '0;
      grant       <= '0;
      hold_cnt    <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      vblank_q    <= vb;
      frame_tick  <= entry;
      frame_cnt   <= entry ? frame_cnt + CNT_W'(1) : frame_cnt;
      served      <= served_n;
      rr_ptr      <= rr_n;
      gi          <= gi_n;
      grant       <= grant_n;
      hold_cnt    <= hold_n;
      overrun     <= overrun_n;
      timeout_err <= timeout_n;
    end
  end
endmodule

// File: tb/tb_vblank_scheduler.sv
// tb_vblank_scheduler: directed self-checking bench for vblank_scheduler
module tb_vblank_scheduler;
  logic clk = 1'b0;
  logic rst;
  logic [9:0] y_ptr;
  logic [3:0] req, done, grant;
  logic frame_tick, busy, overrun, timeout_err;
  logic [15:0] frame_cnt;
  int total = 0;
  int bad = 0;
  int n;
  vblank_scheduler dut (
    .clk(clk), .rst(rst), .y_ptr(y_ptr), .req(req), .done(done), .grant(grant),
    .frame_tick(frame_tick), .frame_cnt(frame_cnt), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic new_frame(input int cnt);
    y_ptr = 10'd0;
    step;
    step;
    y_ptr = 10'd479;
    step;
    y_ptr = 10'd480;
    step;
    chk("tick_on", 32'(frame_tick), 32'd1);
    chk("frame_cnt", 32'(frame_cnt), 32'(cnt));
    step;
    chk("tick_off", 32'(frame_tick), 32'd0);
  endtask
  task automatic serve(input int k, input int hold);
    chk("grant_on", 32'(grant), 32'(1 << k));
    chk("busy_on", 32'(busy), 32'd1);
    repeat (hold) step;
    chk("grant_held", 32'(grant), 32'(1 << k));
    done = 4'(1 << k);
    step;
    done = 4'd0;
    chk("grant_off", 32'(grant), 32'd0);
    chk("busy_off", 32'(busy), 32'd0);
    step;
  endtask
  initial begin
    rst = 1'b1; y_ptr = 10'd500; req = 4'd0; done = 4'd0;
    step;
    step;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_to", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    n = 0;
    repeat (6) begin step; n += int'(frame_tick); end
    chk("no_tick_in_blank", 32'(n), 32'd0);
    new_frame(1);
    chk("idle_no_req", 32'(grant), 32'd0);
    req = 4'b1111;
    new_frame(2);
    for (int k = 0; k < 4; k++) serve(k, 3);
    step;
    chk("all_served", 32'(grant), 32'd0);
    req = 4'b0101;
    new_frame(3);
    serve(0, 3);
    serve(2, 3);
    n = 0;
    repeat (5) begin step; n += int'(grant != 4'd0); end
    chk("no_regrant", 32'(n), 32'd0);
    req = 4'b0110;
    new_frame(4);
    n = 0;
    for (int i = 0; i < 1100 && grant == 4'b0010; i++) begin n++; step; end
    chk("timeout_len", 32'(n), 32'd1024);
    chk("timeout_drop", 32'(grant), 32'd0);
    chk("timeout_err", 32'(timeout_err), 32'd1);
    chk("timeout_no_ovr", 32'(overrun), 32'd0);
    step;
    serve(2, 3);
    req = 4'b0001;
    new_frame(5);
    chk("g0_on", 32'(grant), 32'd1);
    step;
    step;
    y_ptr = 10'd0;
    done = 4'b0001;
    step;
    done = 4'd0;
    chk("done_exit_drop", 32'(grant), 32'd0);
    chk("done_exit_no_ovr", 32'(overrun), 32'd0);
    req = 4'b1000;
    new_frame(6);
    chk("g3_on", 32'(grant), 32'b1000);
    step;
    step;
    y_ptr = 10'd0;
    step;
    chk("ovr_drop", 32'(grant), 32'd0);
    chk("ovr_busy", 32'(busy), 32'd0);
    chk("ovr_set", 32'(overrun), 32'd1);
    step;
    chk("ovr_idle", 32'(grant), 32'd0);
    req = 4'b0001;
    new_frame(7);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    chk("g0_again", 32'(grant), 32'd1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_cnt", 32'(frame_cnt), 32'd0);
    chk("mid_rst_ovr", 32'(overrun), 32'd0);
    chk("mid_rst_to", 32'(timeout_err), 32'd0);
    n = 0;
    repeat (4) begin step; n += int'(frame_tick) + int'(grant != 4'd0); end
    chk("mid_rst_quiet", 32'(n), 32'd0);
    new_frame(1);
    chk("post_rst_grant", 32'(grant), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
